// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder: FSM states, counter sizing
// and reset values.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter wide enough to index WIDTH bit positions (WIDTH >= 2).
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    localparam logic RST_BUSY  = 1'b0;
    localparam logic RST_DONE  = 1'b0;
    localparam logic RST_COUT  = 1'b0;
    localparam logic RST_CARRY = 1'b0;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full-adder cell, the only arithmetic element of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_p;

    assign w_p  = a ^ b;
    assign s    = w_p ^ cin;
    assign cout = (a & b) | (cin & w_p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell and a carry flop produce the sum LSB
// first over WIDTH cycles. Define SERIAL_ADDER_SUB_EN to add the 'sub' port (a - b).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int               CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;
    logic             w_s;
    logic             w_co;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is two's complement: invert B and force the initial carry.
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub ? 1'b1 : cin;
`else
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    full_adder u_cell (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= RST_CARRY;
            r_cout  <= RST_COUT;
            r_busy  <= RST_BUSY;
            r_done  <= RST_DONE;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= w_b_load;
                        r_carry <= w_c_load;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    // New bit enters at the MSB so the LSB result ends up in sum[0].
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    r_carry <= w_co;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST) begin
                        r_cout  <= w_co;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed and random operations checked
// against an arithmetic reference model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {cout, sum} = a + b + cin, or a + ~b + 1 when subtracting.
    function automatic logic [W:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                         input logic tc, input logic ts);
        logic [W:0] ea, eb;
        ea = {1'b0, ta};
        eb = ts ? {1'b0, ~tb_} : {1'b0, tb_};
        return ea + eb + ((ts ? 1'b1 : tc) ? (W+1)'(1) : (W+1)'(0));
    endfunction

    task automatic drive_ops(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                             input logic tc, input logic ts);
        a   = ta;
        b   = tb_;
        cin = tc;
`ifdef SERIAL_ADDER_SUB_EN
        sub = ts;
`endif
    endtask

    // One complete operation; optional start pulse (with junk operands) while busy.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, input logic ts, input int pulse_at);
        logic [W:0] exp;
        int         lat;
        bit         seen;
        exp = model(ta, tb_, tc, ts);
        @(negedge clk);
        drive_ops(ta, tb_, tc, ts);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drive_ops(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        check("busy_rise", busy, 1'b1);
        lat  = 1;
        seen = 0;
        while (!seen && lat < 4 * W) begin
            start = (lat == pulse_at);
            @(posedge clk); #1;
            lat++;
            if (done) seen = 1;
            else if (!busy) break;
        end
        start = 1'b0;
        check("done_seen", seen, 1'b1);
        check("latency", lat, W + 1);
        check("busy_at_done", busy, 1'b1);
        check("sum", sum, exp[W-1:0]);
        check("cout", cout, exp[W]);
        $display("[TB] op a=%02h b=%02h cin=%0b sub=%0b -> sum=%02h cout=%0b (exp %02h/%0b) lat=%0d",
                 ta, tb_, tc, ts, sum, cout, exp[W-1:0], exp[W], lat);
        @(posedge clk); #1;
        check("done_pulse", done, 1'b0);
        check("busy_fall", busy, 1'b0);
        @(posedge clk); #1;
        check("sum_hold", {cout, sum}, exp);
    endtask

    initial begin
        logic [W:0] exp;
        int         cyc;
        int         last_done;
        int         n_done;
        bit         bad_done;

        rst   = 1'b1;
        start = 1'b1;
        drive_ops(8'h35, 8'h1A, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rst_busy", busy, 1'b0);
            check("rst_done", done, 1'b0);
            check("rst_sum", sum, 8'h00);
            check("rst_cout", cout, 1'b0);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        check("idle_after_rst", busy, 1'b0);
        $display("[TB] reset checked");

        run_op(8'h35, 8'h1A, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0);
        run_op(8'h10, 8'h20, 1'b0, 1'b0, 3);

        // Abort in the middle of RUN.
        @(negedge clk);
        drive_ops(8'h55, 8'h66, 1'b1, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_sum", sum, 8'h00);
        check("abort_cout", cout, 1'b0);
        bad_done = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            if (done || busy) bad_done = 1;
        end
        check("abort_quiet", bad_done, 1'b0);
        $display("[TB] abort checked");
        run_op(8'h12, 8'h34, 1'b1, 1'b0, 0);

        // Back-to-back with start held high.
        exp = model(8'hA7, 8'h6C, 1'b1, 1'b0);
        @(negedge clk);
        drive_ops(8'hA7, 8'h6C, 1'b1, 1'b0);
        start     = 1'b1;
        cyc       = 0;
        last_done = 0;
        n_done    = 0;
        while (n_done < 3 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                check("b2b_sum", {cout, sum}, exp);
                check("b2b_period", cyc - last_done, (n_done == 0) ? W + 1 : W + 2);
                $display("[TB] b2b done at cycle %0d sum=%02h cout=%0b", cyc, sum, cout);
                last_done = cyc;
                n_done++;
            end
        end
        start = 1'b0;
        check("b2b_count", n_done, 3);
        cyc = 0;
        while (busy && cyc < 4 * W) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b_drain", busy, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h01, 1'b1, 1'b1, 0);
        run_op(8'h01, 8'h02, 1'b0, 1'b1, 0);
`endif

        for (int i = 0; i < 16; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 7)));
`else
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, int'($urandom_range(0, 7)));
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
